// File: rtl/core_alu_seq_pkg.sv
// Shared ALU definitions: opcode constants, per-opcode writeback masks and sequencer FSM states.
package core_alu_seq_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_ADDC = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_INC  = 5'd3;
  localparam logic [4:0] ALU_DEC  = 5'd4;
  localparam logic [4:0] ALU_MUL  = 5'd5;
  localparam logic [4:0] ALU_DIV  = 5'd6;
  localparam logic [4:0] ALU_DA   = 5'd7;
  localparam logic [4:0] ALU_CPL  = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_OR   = 5'd10;
  localparam logic [4:0] ALU_XOR  = 5'd11;
  localparam logic [4:0] ALU_RL   = 5'd12;
  localparam logic [4:0] ALU_RLC  = 5'd13;
  localparam logic [4:0] ALU_RR   = 5'd14;
  localparam logic [4:0] ALU_RRC  = 5'd15;
  localparam logic [4:0] ALU_SWAP = 5'd16;
  localparam logic [4:0] ALU_COMP = 5'd17;

  // Writeback mask, MSB first: {ACC, B, CY, AC, OV}
  typedef struct packed {
    logic acc;
    logic b;
    logic cy;
    logic ac;
    logic ov;
  } wb_mask_t;

  localparam wb_mask_t WB_NONE   = 5'b00000;
  localparam wb_mask_t WB_ARITH  = 5'b10111;
  localparam wb_mask_t WB_ACC    = 5'b10000;
  localparam wb_mask_t WB_ACC_CY = 5'b10100;
  localparam wb_mask_t WB_CY     = 5'b00100;
  localparam wb_mask_t WB_MULDIV = 5'b11101;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/core_alu_wb_dec.sv
// Combinational opcode to writeback-mask decoder; unknown opcodes write nothing.
module core_alu_wb_dec
  import core_alu_seq_pkg::*;
(
  input  logic [4:0] opcode,
  output wb_mask_t   mask
);

  always_comb begin
    mask = WB_NONE;
    unique case (opcode)
      ALU_ADD, ALU_ADDC, ALU_SUB:                  mask = WB_ARITH;
      ALU_INC, ALU_DEC, ALU_OR, ALU_AND, ALU_XOR,
      ALU_SWAP, ALU_CPL, ALU_RR, ALU_RL:           mask = WB_ACC;
      ALU_RRC, ALU_RLC, ALU_DA:                    mask = WB_ACC_CY;
      ALU_COMP:                                    mask = WB_CY;
      ALU_MUL, ALU_DIV:                            mask = WB_MULDIV;
      default:                                     mask = WB_NONE;
    endcase
  end

endmodule

// File: rtl/core_alu_seq.sv
// Execute-stage sequencer: accepts one request, drives core_alu for 1 or MULDIV_CYCLES cycles,
// then pulses ACC/B/PSW write strobes and exe_done_o for a single cycle.
module core_alu_seq
  import core_alu_seq_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exe_req_i,
  output logic        exe_ready_o,
  input  logic [4:0]  exe_opcode_i,
  input  logic [7:0]  exe_op1_i,
  input  logic [7:0]  exe_op2_i,
  input  logic        exe_cy_i,
  input  logic        exe_ac_i,
  output logic        alu_en_o,
  output logic [4:0]  alu_opcode_o,
  output logic [7:0]  alu_operand1_o,
  output logic [7:0]  alu_operand2_o,
  output logic        alu_cy_o,
  output logic        alu_ac_o,
  input  logic [15:0] alu_result_i,
  input  logic        alu_cy_i,
  input  logic        alu_ov_i,
  input  logic        alu_ac_i,
  output logic        acc_wr_o,
  output logic [7:0]  acc_data_o,
  output logic        b_wr_o,
  output logic [7:0]  b_data_o,
  output logic [2:0]  psw_wr_o,
  output logic [2:0]  psw_data_o,
  output logic        exe_done_o
);

  localparam logic [3:0] HoldMulDiv = 4'(MULDIV_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        alu_en_q, alu_en_d;
  logic [4:0]  opcode_q, opcode_d;
  logic [7:0]  op1_q, op1_d;
  logic [7:0]  op2_q, op2_d;
  logic        cy_q, cy_d;
  logic        ac_q, ac_d;
  logic        acc_wr_q, acc_wr_d;
  logic [7:0]  acc_data_q, acc_data_d;
  logic        b_wr_q, b_wr_d;
  logic [7:0]  b_data_q, b_data_d;
  logic [2:0]  psw_wr_q, psw_wr_d;
  logic [2:0]  psw_data_q, psw_data_d;
  logic        done_q, done_d;

  wb_mask_t    mask;
  logic        div_zero;
  logic [2:0]  flags;

  core_alu_wb_dec u_wb_dec (
    .opcode (opcode_q),
    .mask   (mask)
  );

  // MUL/DIV always clear CY; a zero divisor forces OV and blocks the ACC/B writes.
  assign div_zero = (opcode_q == ALU_DIV) && (op2_q == 8'h00);
  assign flags    = {(is_muldiv(opcode_q) ? 1'b0 : alu_cy_i), alu_ac_i, (alu_ov_i | div_zero)};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_en_d   = alu_en_q;
    opcode_d   = opcode_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    cy_d       = cy_q;
    ac_d       = ac_q;
    acc_wr_d   = 1'b0;
    b_wr_d     = 1'b0;
    psw_wr_d   = 3'b000;
    done_d     = 1'b0;
    acc_data_d = acc_data_q;
    b_data_d   = b_data_q;
    psw_data_d = psw_data_q;

    unique case (state_q)
      StIdle: begin
        if (exe_req_i) begin
          opcode_d = exe_opcode_i;
          op1_d    = exe_op1_i;
          op2_d    = exe_op2_i;
          cy_d     = exe_cy_i;
          ac_d     = exe_ac_i;
          alu_en_d = 1'b1;
          cnt_d    = is_muldiv(exe_opcode_i) ? HoldMulDiv : 4'd1;
          state_d  = StExec;
        end
      end
      StExec: begin
        if (cnt_q <= 4'd1) begin
          state_d  = StDone;
          cnt_d    = 4'd0;
          alu_en_d = 1'b0;
          done_d   = 1'b1;
          acc_wr_d = mask.acc & ~div_zero;
          b_wr_d   = mask.b & ~div_zero;
          psw_wr_d = {mask.cy, mask.ac, mask.ov};
          if (acc_wr_d) acc_data_d = alu_result_i[7:0];
          if (b_wr_d) b_data_d = alu_result_i[15:8];
          if (|psw_wr_d) psw_data_d = flags;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      alu_en_q   <= 1'b0;
      opcode_q   <= 5'd0;
      op1_q      <= 8'h00;
      op2_q      <= 8'h00;
      cy_q       <= 1'b0;
      ac_q       <= 1'b0;
      acc_wr_q   <= 1'b0;
      acc_data_q <= 8'h00;
      b_wr_q     <= 1'b0;
      b_data_q   <= 8'h00;
      psw_wr_q   <= 3'b000;
      psw_data_q <= 3'b000;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_en_q   <= alu_en_d;
      opcode_q   <= opcode_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      cy_q       <= cy_d;
      ac_q       <= ac_d;
      acc_wr_q   <= acc_wr_d;
      acc_data_q <= acc_data_d;
      b_wr_q     <= b_wr_d;
      b_data_q   <= b_data_d;
      psw_wr_q   <= psw_wr_d;
      psw_data_q <= psw_data_d;
      done_q     <= done_d;
    end
  end

  assign exe_ready_o    = (state_q == StIdle);
  assign alu_en_o       = alu_en_q;
  assign alu_opcode_o   = opcode_q;
  assign alu_operand1_o = op1_q;
  assign alu_operand2_o = op2_q;
  assign alu_cy_o       = cy_q;
  assign alu_ac_o       = ac_q;
  assign acc_wr_o       = acc_wr_q;
  assign acc_data_o     = acc_data_q;
  assign b_wr_o         = b_wr_q;
  assign b_data_o       = b_data_q;
  assign psw_wr_o       = psw_wr_q;
  assign psw_data_o     = psw_data_q;
  assign exe_done_o     = done_q;

endmodule

// File: doc/core_alu_seq.md
Name: core_alu_seq

Overview:
Execute-stage sequencer that acts as the initiator toward the combinational core_alu.
- Accepts one ALU operation request from the decoder through a valid/ready handshake.
- Registers the operands, drives the ALU, and holds MUL/DIV for a programmable multi-cycle window.
- Captures the result and flags, then issues one-cycle write strobes for ACC, B and PSW (CY/AC/OV).

Parameters:
MULDIV_CYCLES, 4, ALU hold cycles for ALU_MUL/ALU_DIV (legal 1..15); all other ops hold 1 cycle.

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous reset, active high
exe_req_i  in  1  request valid
exe_ready_o  out  1  sequencer able to accept a request
exe_opcode_i  in  5  ALU_* opcode
exe_op1_i  in  8  operand 1 (ACC)
exe_op2_i  in  8  operand 2 (B/source)
exe_cy_i  in  1  PSW.CY at request
exe_ac_i  in  1  PSW.AC at request
alu_en_o  out  1  to core_alu.alu_en_i
alu_opcode_o  out  5  to core_alu
alu_operand1_o  out  8  to core_alu
alu_operand2_o  out  8  to core_alu
alu_cy_o  out  1  to core_alu.alu_cy_i
alu_ac_o  out  1  to core_alu.alu_ac_i
alu_result_i  in  16  from core_alu
alu_cy_i  in  1  from core_alu
alu_ov_i  in  1  from core_alu
alu_ac_i  in  1  from core_alu
acc_wr_o  out  1  ACC write strobe
acc_data_o  out  8  ACC write data
b_wr_o  out  1  B write strobe
b_data_o  out  8  B write data
psw_wr_o  out  3  flag write mask {CY,AC,OV}
psw_data_o  out  3  flag values {CY,AC,OV}
exe_done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_i=1): state IDLE, exe_ready_o=1. All other outputs 0, including alu_en_o, the alu_* buses, all strobes and data, and exe_done_o. The hold counter is cleared.
- Reset asserted mid-operation aborts the operation immediately. No strobe is issued.
- FSM states:
  - IDLE: exe_ready_o=1. When exe_req_i=1, latch opcode, operands, CY and AC into the alu_* registers; alu_en_o=1; load counter = (MUL|DIV ? MULDIV_CYCLES : 1); go to EXEC.
  - EXEC: exe_ready_o=0; alu_* held stable; counter decrements each cycle. At count 1, register the writeback outputs from the ALU outputs; go to DONE.
  - DONE: strobes and exe_done_o high for exactly this cycle. alu_en_o=0, but the alu_* buses keep their last values. Go to IDLE.
- Latency: request accepted at edge N → exe_done_o high in cycle N+2 for simple ops, N+1+MULDIV_CYCLES for MUL/DIV. The next request can be accepted at the edge after DONE.
- A request while exe_ready_o=0 is ignored; the requester must hold it.
- Writeback table:
  - ADD/ADDC/SUB: ACC=result[7:0]; flag mask CY,AC,OV.
  - INC/DEC/OR/AND/XOR/SWAP/CPL/RR/RL: ACC only; no flags.
  - RRC/RLC/DA: ACC plus CY.
  - COMP: no ACC write; CY only.
  - MUL: ACC=result[7:0], B=result[15:8]; CY←0, OV←alu_ov_i.
  - DIV: ACC=result[7:0] (quotient), B=result[15:8] (remainder); CY←0, OV←alu_ov_i.
  - DIV by zero: ACC and B strobes suppressed; OV=1 and CY=0 are written.
  - Unknown opcode: completes, exe_done_o pulses, no strobes.
- acc_data_o, b_data_o and psw_data_o are valid only while their strobes are high and hold their values otherwise.

Decomposition:
- Shared package, i.e. the instruction-set define file:
  - ALU_* opcode constants.
  - Per-opcode writeback mask constants {ACC,B,CY,AC,OV}.
  - FSM state encodings for IDLE/EXEC/DONE.
- One natural sub-module: core_alu_wb_dec, a combinational opcode → writeback-mask decoder.

Test Plan:
- ADD 0xC3+0xAA, CY=0 → done at N+2; ACC=0x6D; psw_wr=111; CY=1, AC=0, OV=1.
- MUL 0x50×0xA0, MULDIV_CYCLES=4 → done at N+5; ACC=0x00, B=0x32; CY=0, OV=1; alu_* stable for 4 cycles.
- DIV 0xFB/0x12 → ACC=0x0D, B=0x11, OV=0. DIV 0xB3/0x00 → no ACC/B strobe; psw_wr CY+OV, OV=1.
- COMP 0x34 vs 0x56 → acc_wr=0; psw_wr=100, CY=1. INC 0xFF → ACC=0x00, psw_wr=000.
- Back-to-back: exe_req_i held high across two ADDs → second accepted only after DONE, exactly one done pulse each; a request during EXEC is not lost.
- rst_i pulsed mid-MUL (cycle 2 of EXEC) → all outputs 0 asynchronously, no strobes; a fresh ADD afterwards completes normally.
